ex_forward_ctrl: RTL
====================

Name: ex_forward_ctrl

Overview:
- Forwarding and hazard controller for the RV32 5-stage pipeline.
- Sits directly upstream of the two EX-stage 3-to-1 operand muxes and drives their 2-bit selectors.
- Tracks destination registers in flight through EX, MEM and WB.
- Produces per-operand forwarding selects, a load-use stall, and a saturating stall-event counter.

Parameters:
- REG_BITS, 5, register-index width.
- CNT_BITS, 16, width of the stall-event counter.

Ports:
- Clk  input  1  pipeline clock; rising edge.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- ID_Rs1  input  REG_BITS  rs1 index of the instruction in ID.
- ID_Rs2  input  REG_BITS  rs2 index of the instruction in ID.
- ID_Rd  input  REG_BITS  rd index of the instruction in ID.
- ID_RegWrite  input  1  ID instruction writes rd.
- ID_MemRead  input  1  ID instruction is a load.
- Flush  input  1  branch/jump taken; squash the instruction entering EX.
- Sel_A  output  2  selector for the rs1 operand mux.
- Sel_B  output  2  selector for the rs2 operand mux.
- Stall  output  1  hold PC and IF/ID; insert bubble into EX.
- Stall_Count  output  CNT_BITS  number of load-use stalls since reset, saturating.

Behaviour:
- Selector encoding, matching the operand mux input order:
  - 0 = register-file value.
  - 1 = EX/MEM ALU result.
  - 2 = MEM/WB writeback value.
  - 3 is never driven.
- Internal slots, all flops on the async Reset:
  - EX slot: {Rs1, Rs2, Rd, RegWrite, MemRead}.
  - MEM slot: {Rd, RegWrite, MemRead}.
  - WB slot: {Rd, RegWrite}.
- Reset, taking effect without a clock edge:
  - All slot fields = 0.
  - Sel_A = Sel_B = 0, Stall = 0, Stall_Count = 0.
- Each rising edge (Reset low):
  - MEM <= EX fields. WB <= MEM fields. These always advance.
  - If Flush or Stall: EX <= bubble, i.e. all fields 0.
  - Otherwise: EX <= ID inputs.
  - If Stall and Stall_Count != all-ones: Stall_Count increments.
- Sel_A is combinational from registered slots only; there is no path from ID inputs:
  - Sel_A = 1 if MEM.RegWrite, !MEM.MemRead, MEM.Rd != 0 and MEM.Rd == EX.Rs1.
  - Else Sel_A = 2 if WB.RegWrite, WB.Rd != 0 and WB.Rd == EX.Rs1.
  - Else Sel_A = 0.
  - MEM has priority over WB because it holds the younger result.
- Sel_B: same rules as Sel_A, using EX.Rs2.
- Register x0 never forwards.
- Stall (combinational):
  - Stall = EX.MemRead && EX.Rd != 0 && (EX.Rd == ID_Rs1 || EX.Rd == ID_Rs2) && !Flush.
  - Flush overrides Stall.
- Load-use sequence:
  - Cycle n: load in EX, dependent instruction in ID → Stall = 1.
  - Cycle n+1: bubble in EX, load in MEM, dependent instruction still in ID → Stall = 0.
  - Cycle n+2: dependent instruction in EX, load in WB → selector = 2.
- Stall lasts exactly one cycle per load-use pair.
- Flush with no stall: one bubble enters EX.
- Reset asserted mid-stall or mid-flush: all state clears at once. The first post-reset edge loads EX from the ID inputs.
- Counter holds at 2^CNT_BITS-1; no wrap.

Test Plan:
- Reset: assert Reset with no clock → Sel_A = Sel_B = 0, Stall = 0, Stall_Count = 0 immediately.
- ALU chain: add x5 (Rd=5, RegWrite=1), then Rs1=5 → next cycle Sel_A = 1. Two edges later, with a non-writing filler in between, Sel_A = 2.
- Priority: x7 written in consecutive instructions, then Rs2=7 → Sel_B = 1 (MEM wins over WB).
- x0: Rd=0 with RegWrite=1, followed by Rs1=0, Rs2=0 → Sel_A = Sel_B = 0.
- Load-use: load Rd=3, then ID_Rs2=3 → Stall = 1 for one cycle. Stall_Count goes 0→1. When the dependent instruction reaches EX, Sel_B = 2.
- Flush vs stall: load-use condition present with Flush = 1 → Stall = 0, EX bubble, Stall_Count unchanged. Saturation check with CNT_BITS=2: four stalls → Stall_Count = 3.

Source files
------------

// File: rtl/ex_forward_ctrl.sv
// ex_forward_ctrl: EX-stage operand forwarding and load-use hazard control for
// the RV32 5-stage pipeline. Tracks in-flight destinations in EX/MEM/WB slots,
// drives the two operand-mux selectors, raises a one-cycle load-use stall and
// counts stall events with a saturating counter.
module ex_forward_ctrl #(
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [REG_BITS-1:0] ID_Rs1,
    input  logic [REG_BITS-1:0] ID_Rs2,
    input  logic [REG_BITS-1:0] ID_Rd,
    input  logic                ID_RegWrite,
    input  logic                ID_MemRead,
    input  logic                Flush,
    output logic [1:0]          Sel_A,
    output logic [1:0]          Sel_B,
    output logic                Stall,
    output logic [CNT_BITS-1:0] Stall_Count
);

    // Operand mux input order
    localparam logic [1:0] SEL_RF    = 2'd0;
    localparam logic [1:0] SEL_EXMEM = 2'd1;
    localparam logic [1:0] SEL_MEMWB = 2'd2;

    // EX slot
    logic [REG_BITS-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_BITS-1:0] ex_rs2_q, ex_rs2_d;
    logic [REG_BITS-1:0] ex_rd_q,  ex_rd_d;
    logic                ex_rw_q,  ex_rw_d;
    logic                ex_mr_q,  ex_mr_d;

    // MEM slot
    logic [REG_BITS-1:0] mem_rd_q;
    logic                mem_rw_q;
    logic                mem_mr_q;

    // WB slot
    logic [REG_BITS-1:0] wb_rd_q;
    logic                wb_rw_q;

    // Stall-event counter
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    // Selector for one operand. MEM holds the younger result so it is checked
    // first; a load in MEM has no data yet on the EX/MEM ALU path, so it is
    // skipped and WB may still supply an older value. x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_BITS-1:0] rs,
        input logic [REG_BITS-1:0] m_rd,
        input logic                m_rw,
        input logic                m_mr,
        input logic [REG_BITS-1:0] w_rd,
        input logic                w_rw
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (m_rw && !m_mr && (m_rd != '0) && (m_rd == rs))
            sel = SEL_EXMEM;
        else if (w_rw && (w_rd != '0) && (w_rd == rs))
            sel = SEL_MEMWB;
        return sel;
    endfunction

    // Forwarding selects come from registered slots only
    always_comb begin
        Sel_A = fwd_sel(ex_rs1_q, mem_rd_q, mem_rw_q, mem_mr_q, wb_rd_q, wb_rw_q);
        Sel_B = fwd_sel(ex_rs2_q, mem_rd_q, mem_rw_q, mem_mr_q, wb_rd_q, wb_rw_q);
    end

    // Load-use hazard: load in EX feeding the instruction in ID; a flush wins
    always_comb begin
        Stall = ex_mr_q && (ex_rd_q != '0)
                && ((ex_rd_q == ID_Rs1) || (ex_rd_q == ID_Rs2))
                && !Flush;
    end

    // Next EX contents: a bubble on flush or stall, otherwise the ID instruction
    always_comb begin
        ex_rs1_d = ID_Rs1;
        ex_rs2_d = ID_Rs2;
        ex_rd_d  = ID_Rd;
        ex_rw_d  = ID_RegWrite;
        ex_mr_d  = ID_MemRead;
        if (Flush || Stall) begin
            ex_rs1_d = '0;
            ex_rs2_d = '0;
            ex_rd_d  = '0;
            ex_rw_d  = 1'b0;
            ex_mr_d  = 1'b0;
        end
    end

    // Counter saturates at all-ones instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (Stall && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    // Slot pipeline: MEM and WB always advance, EX takes the next-state value
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
            ex_rd_q  <= '0;
            ex_rw_q  <= 1'b0;
            ex_mr_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_rw_q <= 1'b0;
            mem_mr_q <= 1'b0;
            wb_rd_q  <= '0;
            wb_rw_q  <= 1'b0;
        end else begin
            ex_rs1_q <= ex_rs1_d;
            ex_rs2_q <= ex_rs2_d;
            ex_rd_q  <= ex_rd_d;
            ex_rw_q  <= ex_rw_d;
            ex_mr_q  <= ex_mr_d;
            mem_rd_q <= ex_rd_q;
            mem_rw_q <= ex_rw_q;
            mem_mr_q <= ex_mr_q;
            wb_rd_q  <= mem_rd_q;
            wb_rw_q  <= mem_rw_q;
        end
    end

    // Stall-event counter register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign Stall_Count = cnt_q;

endmodule
